random_pulse_generator: RTL and testbench
=========================================

Name: random_pulse_generator

Overview:
- Pseudo-random pulse generator for a TinyTapeout-style tile.
- Emits single-cycle pulses whose average rate is set by a 4-bit rate code. Higher code means more frequent pulses.
- Inter-pulse spacing is jittered by a 16-bit LFSR.
- The rate code comes either directly from input pins or from an on-chip rotary-encoder-driven register.

Parameters:
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.
- ENC_RESET_RATE, 4'd8, reset value of the encoder rate register.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, reset; synchronous, active-high.
- ena, input, 1, tile enable; ignored.
- ui_in, input, 8, control inputs:
  - [3:0] direct rate code
  - [4] encoder A
  - [5] encoder B
  - [6] rate source select (1 = encoder register)
  - [7] unused
- uo_out, output, 8, status outputs:
  - [0] pulse
  - [1] toggle
  - [7:2] pulse count, modulo 64
- uio_in, input, 8, unused.
- uio_out, output, 8, LFSR[7:0].
- uio_oe, output, 8, constant 8'hFF.

Behaviour:
- All registers update on the rising edge of clk. When rst=1 at an edge, every register takes its reset value. rst has priority over all other activity, including mid-interval.
- Reset values:
  - lfsr = LFSR_SEED
  - countdown = 6'd31
  - pulse = 0, toggle = 0, count = 0
  - enc_rate = ENC_RESET_RATE
  - encoder synchronizers and previous-A register = 0
- LFSR: 16-bit Galois, right shift.
  - Update: next = {1'b0, lfsr[15:1]} XOR (lfsr[0] ? 16'hB400 : 16'h0000).
  - Advances every non-reset cycle; never reaches zero.
  - Period is 65535.
- Rate select: R = ui_in[6] ? enc_rate : ui_in[3:0].
  - R is sampled combinationally on the reload cycle.
  - A change in R affects only the next reload.
- Countdown, 6-bit unsigned:
  - If countdown == 0: pulse <= 1; countdown <= ((15 - R) << 1) + lfsr[2:0] (uses the current, pre-update LFSR value); count <= count + 1 (wraps 63 → 0); toggle <= ~toggle.
  - Otherwise: pulse <= 0; countdown <= countdown - 1.
  - The reload value is at most 37, so it fits in 6 bits with no overflow.
- Resulting spacing between consecutive pulse rising edges = ((15 - R) × 2) + lfsr[2:0] + 1 cycles.
  - R=15: 1 to 8 cycles.
  - R=0: 31 to 38 cycles.
  - With spacing 1, pulse stays high on consecutive cycles (back-to-back pulses are legal).
- First pulse: uo_out[0] = 1 exactly 32 cycles after the first non-reset edge.
  - The edge that sees countdown == 0 is the 32nd non-reset edge; pulse is high after it.
- Pulse width: exactly 1 cycle per countdown expiry.
- Rotary encoder:
  - ui_in[4] and ui_in[5] each pass through a 2-FF synchronizer.
  - On a synchronized A rising edge (A_sync=1 and prev_A=0):
    - B_sync == 0: enc_rate increments, saturating at 15.
    - B_sync == 1: enc_rate decrements, saturating at 0.
  - Encoder tracking runs regardless of ui_in[6].
  - Simultaneous A and B changes are resolved by the synchronized values only.
- Outputs:
  - uo_out = {count[5:0], toggle, pulse}, all registered.
  - uio_out = lfsr[7:0].
  - uio_oe = 8'hFF always, including during reset.
- ui_in[7], uio_in and ena do not affect any state.

Test Plan:
- Reset, then release with ui_in=0 → uo_out=0 for 31 cycles; uo_out[0]=1 on cycle 32 for exactly one cycle; count=1, toggle=1; uio_oe=8'hFF throughout.
- Hold rst=1 for 5 edges → uio_out=8'hE1 (LFSR_SEED[7:0]) and uo_out=0. After release, the LFSR sequence follows the Galois rule: first value 16'h5670 ^ 16'hB400 = 16'hE270, since lfsr[0] of 16'hACE1 is 1.
- ui_in=8'h0F → all pulse spacings within 1 to 8 cycles. ui_in=8'h01 → spacings within 29 to 36. ui_in=8'h05 → spacings within 21 to 28. Cross-check every spacing against a reference LFSR model.
- ui_in[6]=1, 10 encoder A rising edges with B=0 → enc_rate saturates at 15 (spacings ≤ 8). Then 20 edges with B=1 → enc_rate = 0 (spacings 31 to 38).
- Run more than 64 pulses → count wraps 63 → 0 and toggle alternates every pulse. Assert rst mid-countdown → all outputs are at reset values on the next cycle.

Source files
------------

// File: rtl/random_pulse_generator.sv
// Pseudo-random pulse generator: a 6-bit countdown reloaded from a rate code
// plus LFSR jitter, with a rotary-encoder-driven rate register as an alternate rate source.
module random_pulse_generator #(
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter logic [3:0]  ENC_RESET_RATE = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  countdown_q, countdown_d;
  logic        pulse_q, pulse_d;
  logic        toggle_q, toggle_d;
  logic [5:0]  count_q, count_d;
  logic [3:0]  enc_rate_q, enc_rate_d;
  logic        a_meta_q, a_sync_q, a_prev_q;
  logic        b_meta_q, b_sync_q;
  logic [3:0]  rate;
  logic        a_rise;

  // Tile enable, bidirectional inputs and ui_in[7] carry no function.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7]};

  always_comb begin
    rate   = ui_in[6] ? enc_rate_q : ui_in[3:0];
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    countdown_d = countdown_q - 6'd1;
    pulse_d     = 1'b0;
    count_d     = count_q;
    toggle_d    = toggle_q;
    // Reload uses the pre-advance LFSR; max value 30 + 7 fits in 6 bits.
    if (countdown_q == 6'd0) begin
      countdown_d = {1'b0, 4'd15 - rate, 1'b0} + {3'b000, lfsr_q[2:0]};
      pulse_d     = 1'b1;
      count_d     = count_q + 6'd1;
      toggle_d    = ~toggle_q;
    end

    a_rise     = a_sync_q & ~a_prev_q;
    enc_rate_d = enc_rate_q;
    if (a_rise) begin
      if (!b_sync_q) begin
        if (enc_rate_q != 4'd15) enc_rate_d = enc_rate_q + 4'd1;
      end else begin
        if (enc_rate_q != 4'd0) enc_rate_d = enc_rate_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q      <= LFSR_SEED;
      countdown_q <= 6'd31;
      pulse_q     <= 1'b0;
      toggle_q    <= 1'b0;
      count_q     <= 6'd0;
      enc_rate_q  <= ENC_RESET_RATE;
      a_meta_q    <= 1'b0;
      a_sync_q    <= 1'b0;
      a_prev_q    <= 1'b0;
      b_meta_q    <= 1'b0;
      b_sync_q    <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      countdown_q <= countdown_d;
      pulse_q     <= pulse_d;
      toggle_q    <= toggle_d;
      count_q     <= count_d;
      enc_rate_q  <= enc_rate_d;
      a_meta_q    <= ui_in[4];
      a_sync_q    <= a_meta_q;
      a_prev_q    <= a_sync_q;
      b_meta_q    <= ui_in[5];
      b_sync_q    <= b_meta_q;
    end
  end

  assign uo_out  = {count_q, toggle_q, pulse_q};
  assign uio_out = lfsr_q[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_random_pulse_generator.sv
// Bench for random_pulse_generator: a reference model predicts each pulse
// (edge, count, toggle, LFSR byte) into a queue that a negedge monitor drains.
module tb_random_pulse_generator;

  localparam int W = 47;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] exp_q[$];

  // Stimulus fields composing ui_in
  logic [3:0] rate_code = 4'd0;
  logic       enc_a = 1'b0, enc_b = 1'b0, sel = 1'b0;
  logic [3:0] enc_model = 4'd8;

  // Spacing range check
  logic range_en = 1'b0;
  int   range_lo = 0, range_hi = 0;
  int   pulse_seen = 0;
  int   last_pulse = -1;
  int   mon_edges = 0;

  random_pulse_generator dut (
    .clk(clk), .rst(rst), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(posedge clk) mon_edges <= rst ? 0 : mon_edges + 1;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    vectors++;
    errors++;
    $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Drivers
  task automatic drive_ui();
    ui_in = {1'($urandom_range(0, 1)), sel, enc_b, enc_a, rate_code};
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int k);
    int start;
    bit done;
    start = pulse_seen;
    done  = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      wait_cycles(1);
      if (pulse_seen >= start + k) done = 1'b1;
    end
    if (!done) fail_now("pulse_timeout", pulse_seen - start, k);
  endtask

  task automatic enc_edge(input logic b);
    enc_b = b; drive_ui(); wait_cycles(3);
    enc_a = 1'b1; drive_ui(); wait_cycles(4);
    enc_a = 1'b0; drive_ui(); wait_cycles(4);
  endtask

  task automatic run_phase(input logic [3:0] code, input logic s, input int lo, input int hi, input int cycles);
    range_en = 1'b0;
    rate_code = code; sel = s; drive_ui();
    wait_pulses(2);
    range_lo = lo; range_hi = hi; range_en = 1'b1;
    wait_cycles(cycles);
    range_en = 1'b0;
  endtask

  // Reference model: predicts the edge of each pulse and the outputs after it
  initial begin : model
    logic [15:0] m_lfsr, prev;
    int m_edge, m_next, r;
    logic [5:0] m_cnt;
    logic m_tog;
    m_lfsr = 16'hACE1; m_edge = 0; m_next = 32; m_cnt = 6'd0; m_tog = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_lfsr = 16'hACE1; m_edge = 0; m_next = 32; m_cnt = 6'd0; m_tog = 1'b0;
      end else begin
        m_edge++;
        prev   = m_lfsr;
        m_lfsr = {1'b0, prev[15:1]} ^ (prev[0] ? 16'hB400 : 16'h0000);
        if (m_edge == m_next) begin
          m_cnt  = m_cnt + 6'd1;
          m_tog  = ~m_tog;
          r      = ui_in[6] ? int'(enc_model) : int'(ui_in[3:0]);
          m_next = m_edge + 2 * (15 - r) + int'(prev[2:0]) + 1;
          exp_q.push_back({32'(m_edge), m_cnt, m_tog, m_lfsr[7:0]});
        end
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    int sp;
    check8("uio_oe", uio_oe, 8'hFF);
    if (mon_edges == 0) begin
      if (exp_q.size() != 0) begin
        fail_now("missed_pulse_before_reset", 0, exp_q.size());
        exp_q.delete();
      end
      last_pulse = -1;
    end else begin
      while (exp_q.size() != 0 && int'(exp_q[0][46:15]) < mon_edges) begin
        e = exp_q.pop_front();
        fail_now("missed_pulse_edge", mon_edges, int'(e[46:15]));
      end
      if (uo_out[0]) begin
        pulse_seen++;
        if (exp_q.size() == 0 || int'(exp_q[0][46:15]) != mon_edges) begin
          fail_now("unexpected_pulse_edge", mon_edges, exp_q.size() == 0 ? -1 : int'(exp_q[0][46:15]));
        end else begin
          e = exp_q.pop_front();
          check8("pulse_uo_out", uo_out, {e[14:9], e[8], 1'b1});
          check8("pulse_lfsr", uio_out, e[7:0]);
        end
        if (range_en && last_pulse >= 0) begin
          sp = mon_edges - last_pulse;
          vectors++;
          if (sp < range_lo || sp > range_hi) begin
            errors++;
            $display("FAIL spacing: got %0d expected %0d..%0d", sp, range_lo, range_hi);
          end
        end
        last_pulse = mon_edges;
      end
    end
  end

  // Directed sequence
  initial begin
    drive_ui();
    ui_in = 8'h00;
    repeat (5) @(negedge clk);
    #1;
    check8("reset_lfsr", uio_out, 8'hE1);
    check8("reset_uo", uo_out, 8'h00);
    rst = 1'b0;
    wait_cycles(1);
    check8("lfsr_first", uio_out, 8'h70);
    wait_cycles(30);
    check8("before_first_pulse", uo_out, 8'h00);
    wait_cycles(1);
    check8("first_pulse", uo_out, 8'h07);
    wait_cycles(1);
    check8("after_first_pulse", uo_out, 8'h06);

    // Fast rate: many pulses so the count wraps past 63
    run_phase(4'hF, 1'b0, 1, 8, 400);
    run_phase(4'h1, 1'b0, 29, 36, 300);

    // Reset mid-countdown
    wait_pulses(1);
    wait_cycles(10);
    rst = 1'b1;
    wait_cycles(1);
    check8("midreset_uo", uo_out, 8'h00);
    check8("midreset_lfsr", uio_out, 8'hE1);
    rst = 1'b0;

    run_phase(4'h5, 1'b0, 21, 28, 250);

    // Encoder ramp up while direct source is selected, then switch over
    rate_code = 4'hF; sel = 1'b0; drive_ui();
    for (int i = 0; i < 10; i++) enc_edge(1'b0);
    enc_model = 4'd15;
    run_phase(4'h0, 1'b1, 1, 8, 100);

    rate_code = 4'hF; sel = 1'b0; drive_ui();
    for (int i = 0; i < 20; i++) enc_edge(1'b1);
    enc_model = 4'd0;
    run_phase(4'hF, 1'b1, 31, 38, 250);

    wait_cycles(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
